// File: rtl/vx_tcu_seq_pkg.sv
// Shared types for the FEDP beat sequencer: FSM state encoding and source format codes.
package vx_tcu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      NEXT,
      DONE
   } seq_state_e;

   localparam logic [2:0] FMT_FP16 = 3'd1;
   localparam logic [2:0] FMT_BF16 = 3'd2;

endpackage

// File: rtl/vx_tcu_seq_ctrl.sv
// Sequencer control: FSM, FEDP latency counter, beat counter and last-beat flag.
// Optional busy-cycle counter when TCU_SEQ_PERF_EN is defined.
module vx_tcu_seq_ctrl
   import vx_tcu_seq_pkg::*;
#(
   parameter int unsigned LATENCY   = 4,
   parameter int unsigned MAX_BEATS = 16,
   parameter int unsigned BW        = $clog2(MAX_BEATS + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic          in_last,
   input  logic          out_ready,
   output logic          in_ready,
   output logic          out_valid,
   output logic          fedp_enable,
   output logic          load_first,
   output logic          load_next,
   output logic          capture,
   output logic [BW-1:0] beats
`ifdef TCU_SEQ_PERF_EN
   ,output logic [31:0]  perf_busy_cycles
`endif
);

   localparam int unsigned CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
   localparam logic [CW-1:0] CNT_INIT  = CW'(LATENCY);
   localparam logic [BW-1:0] BEATS_MAX = BW'(MAX_BEATS);

   seq_state_e    state;
   logic [CW-1:0] cnt;
   logic          last_q;
   logic          accept;

   assign accept     = in_valid && in_ready;
   assign load_first = accept && (state == IDLE);
   assign load_next  = accept && (state == NEXT);
   assign capture    = (state == WAIT) && (cnt == '0);

   // in_ready is registered and tracks the next state, so neither in_valid nor out_ready reach it combinationally.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         beats       <= '0;
         last_q      <= 1'b0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         fedp_enable <= 1'b0;
      end else begin
         fedp_enable <= 1'b1;
         unique case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (accept) begin
                  beats    <= BW'(1);
                  last_q   <= in_last || (MAX_BEATS == 1);
                  cnt      <= CNT_INIT;
                  in_ready <= 1'b0;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  out_valid <= last_q;
                  in_ready  <= !last_q;
                  state     <= last_q ? DONE : NEXT;
               end
            end
            NEXT: begin
               if (accept) begin
                  beats    <= beats + BW'(1);
                  last_q   <= in_last || (beats + BW'(1) == BEATS_MAX);
                  cnt      <= CNT_INIT;
                  in_ready <= 1'b0;
                  state    <= WAIT;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef TCU_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_busy_cycles <= '0;
      end else if (state != IDLE) begin
         perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: rtl/vx_tcu_fedp_seq.sv
// Beat sequencer upstream of the FEDP: chains each beat's d_val into the next beat's c_val.
// Define TCU_SEQ_PERF_EN to add the perf_busy_cycles output.
module vx_tcu_fedp_seq
   import vx_tcu_seq_pkg::*;
#(
   parameter int unsigned N         = 4,
   parameter int unsigned LATENCY   = 4,
   parameter int unsigned MAX_BEATS = 16,
   parameter int unsigned XLEN      = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [2:0]                       in_fmt_s,
   input  logic [XLEN-1:0]                  in_c_val,
   input  logic [N*XLEN-1:0]                in_a_row,
   input  logic [N*XLEN-1:0]                in_b_col,
   input  logic                             in_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [XLEN-1:0]                  out_d_val,
   output logic [$clog2(MAX_BEATS+1)-1:0]   out_beats,
   output logic                             fedp_enable,
   output logic [2:0]                       fedp_fmt_s,
   output logic [N*XLEN-1:0]                fedp_a_row,
   output logic [N*XLEN-1:0]                fedp_b_col,
   output logic [XLEN-1:0]                  fedp_c_val,
   input  logic [XLEN-1:0]                  fedp_d_val
`ifdef TCU_SEQ_PERF_EN
   ,output logic [31:0]                     perf_busy_cycles
`endif
);

   logic            load_first;
   logic            load_next;
   logic            capture;
   logic [XLEN-1:0] acc;

   vx_tcu_seq_ctrl #(
      .LATENCY   (LATENCY),
      .MAX_BEATS (MAX_BEATS),
      .BW        ($clog2(MAX_BEATS + 1))
   ) u_ctrl (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_last          (in_last),
      .out_ready        (out_ready),
      .in_ready         (in_ready),
      .out_valid        (out_valid),
      .fedp_enable      (fedp_enable),
      .load_first       (load_first),
      .load_next        (load_next),
      .capture          (capture),
      .beats            (out_beats)
`ifdef TCU_SEQ_PERF_EN
      ,.perf_busy_cycles(perf_busy_cycles)
`endif
   );

   // Format and initial accumulator come from the first beat only; later beats chain acc.
   always_ff @(posedge clk) begin
      if (reset) begin
         fedp_fmt_s <= '0;
         fedp_c_val <= '0;
         fedp_a_row <= '0;
         fedp_b_col <= '0;
         acc        <= '0;
      end else begin
         if (load_first) begin
            fedp_fmt_s <= in_fmt_s;
            fedp_c_val <= in_c_val;
         end else if (load_next) begin
            fedp_c_val <= acc;
         end
         if (load_first || load_next) begin
            fedp_a_row <= in_a_row;
            fedp_b_col <= in_b_col;
         end
         if (capture) begin
            acc <= fedp_d_val;
         end
      end
   end

   assign out_d_val = acc;

endmodule

// File: doc/vx_tcu_fedp_seq.md
# vx_tcu_fedp_seq

Beat sequencer sitting directly upstream of the tensor-core FEDP (fused dot-product) stage. Accepts a job as a stream of K operand beats (a_row/b_col vectors), issues each beat to the FEDP with the running accumulator as c_val, captures d_val after the FEDP latency, and chains it into the next beat. Emits the final accumulated dot product on a valid/ready output. One beat in flight at a time.

## Interface
- N, 4, dot-product lanes per beat (must match the FEDP's N)
- LATENCY, 4, FEDP pipeline latency in cycles (0 allowed)
- MAX_BEATS, 16, maximum beats per job
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_fmt_s  in  3  source format (1=fp16, 2=bf16); sampled on first beat only
- in_c_val  in  XLEN  initial accumulator; sampled on first beat only
- in_a_row  in  N*XLEN  packed A operands
- in_b_col  in  N*XLEN  packed B operands
- in_last  in  1  final beat of job
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_d_val  out  XLEN  final accumulated result
- out_beats  out  clog2(MAX_BEATS+1)  beats processed in this job
- fedp_enable  out  1  FEDP pipeline enable
- fedp_fmt_s  out  3  to FEDP fmt_s
- fedp_a_row / fedp_b_col  out  N*XLEN  registered operands to FEDP
- fedp_c_val  out  XLEN  registered accumulator to FEDP
- fedp_d_val  in  XLEN  FEDP result

## Operation
- States: IDLE, WAIT, NEXT, DONE.
- IDLE: in_ready=1. On accept: latch fmt_s; fedp_c_val<=in_c_val; fedp_a_row/b_col<=beat; beats<=1; last flag<=in_last || (MAX_BEATS==1); cnt<=LATENCY; ->WAIT.
- WAIT: in_ready=0. cnt decrements each cycle; when cnt==0, acc<=fedp_d_val; ->DONE if last flag, else ->NEXT.
- NEXT: in_ready=1. On accept: fedp_c_val<=acc; operands<=beat; beats++; last flag<=in_last || (beats+1==MAX_BEATS); cnt<=LATENCY; ->WAIT. in_fmt_s/in_c_val ignored.
- DONE: out_valid=1, out_d_val=acc, out_beats=beats. On out_ready: ->IDLE. Result holds stable while stalled.
- fedp_enable=1 in all states except during reset (FEDP is never stalled; only one beat in flight, so no output backpressure reaches it).
- Beat count saturation: the MAX_BEATS-th beat terminates the job regardless of in_last; any subsequent beats belong to a new job (their in_c_val is sampled as fresh init).
- acc is not re-rounded or modified; it is the FEDP's raw XLEN result.

## Timing
- Beat accepted at cycle t: operands on fedp_* at t+1; d_val sampled at end of cycle t+1+LATENCY; next beat acceptable at t+2+LATENCY; out_valid at t+2+LATENCY for a last beat.
- Throughput: one beat per LATENCY+2 cycles. K-beat job latency, from first accept to out_valid: K*(LATENCY+2) cycles.
- Reset values: in_ready=0 while reset is asserted, 1 the cycle after (IDLE); out_valid=0; out_d_val=0; out_beats=0; fedp_enable=0; fedp_* operands=0; state=IDLE.
- Reset mid-job (any state): job discarded, no out_valid, back to IDLE next cycle.
- in_valid is ignored while in_ready=0. No combinational path from in_valid to in_ready, or from out_ready to in_ready (IDLE is re-entered one cycle after the handshake).

## Configuration
- TCU_SEQ_PERF_EN defined: adds output perf_busy_cycles (32 bits). It counts cycles with state!=IDLE, wraps at 2^32, and resets to 0 on reset only (not per job).
- TCU_SEQ_PERF_EN undefined: port and counter are absent. Functional behaviour is identical.

## Structure
- Package vx_tcu_seq_pkg: state enum (IDLE/WAIT/NEXT/DONE), format constants FMT_FP16=3'd1 and FMT_BF16=3'd2.
- Sub-module vx_tcu_seq_ctrl: FSM, latency counter, beat counter and last flag. It outputs load/capture strobes.
- Top level: operand/accumulator registers and port muxing.

## Test plan
- N=1, LATENCY=4, fp16, one beat: a={3C00,3C00}, b={4000,4000}, c=0, last=1 -> out_d_val=32'h40800000 (4.0), out_beats=1, out_valid exactly 6 cycles after accept.
- Same operands, three beats, c=32'h3F800000 -> intermediate fedp_c_val 5.0 then 9.0; final out_d_val=32'h41500000 (13.0), out_beats=3, out_valid at 18 cycles.
- out_ready held low 10 cycles in DONE -> out_valid/out_d_val stable; in_ready=0 throughout; IDLE one cycle after handshake.
- MAX_BEATS=2, three beats with in_last only on the third -> two results: job 1 out_beats=2; job 2 (third beat, own c) out_beats=1.
- Reset asserted in WAIT of beat 2 -> no out_valid; all outputs at reset values; a new single-beat job then completes correctly.
- LATENCY=0, TCU_SEQ_PERF_EN defined, one beat -> out_valid 2 cycles after accept; perf_busy_cycles=2 after the handshake.
